// File: rtl/mux_fifo_pkg.sv
// Shared constants and types for the mux output FIFO.
//   WIDTH_DEF / DEPTH_DEF : default data width and entry count
//   PTR_W / CNT_W         : pointer and occupancy-counter widths for the defaults
//   fifo_op_e / decode_op : classification of one clock edge's handshakes
package mux_fifo_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned PTR_W     = $clog2(DEPTH_DEF);
  localparam int unsigned CNT_W     = PTR_W + 1;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_BOTH = 2'd3
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    fifo_op_e op;
    op = OP_IDLE;
    if (push && pop) begin
      op = OP_BOTH;
    end else if (push) begin
      op = OP_PUSH;
    end else if (pop) begin
      op = OP_POP;
    end
    return op;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping pointer counter for the FIFO.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, forces ptr to 0
//   inc   : advance ptr by one this edge
//   ptr   : current pointer, wraps from 2**W-1 to 0
module fifo_ptr
  import mux_fifo_pkg::*;
#(
  parameter int unsigned W = PTR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // W = log2(DEPTH) with DEPTH a power of two, so natural overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/mux_out_fifo.sv
// Small FIFO buffering the 2:1 mux output byte stream for the display stage.
//   clk, rst_n           : clock (rising edge) and asynchronous active-low reset
//   in_data/in_valid     : upstream offer; in_ready = !full accepts it
//   out_data/out_valid   : registered head entry; out_ready pops it
//   clr_err              : synchronous clear of drop_err (a new drop wins)
//   count, full, empty   : occupancy status
//   drop_err             : sticky, set when data is offered while full
module mux_out_fifo
  import mux_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     clr_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     drop_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_q;
  logic             push;
  logic             pop;
  fifo_op_e         op;

  assign full      = (cnt_q == FULL_CNT);
  assign empty     = (cnt_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = cnt_q;

  // Handshakes depend only on registered occupancy, so a push into an empty
  // FIFO cannot appear on the output in the same cycle.
  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign op   = decode_op(push, pop);

  fifo_ptr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately not reset; emptiness is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  assign out_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      case (op)
        OP_PUSH: cnt_q <= cnt_q + CW'(1);
        OP_POP:  cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_err <= 1'b0;
    end else if (in_valid && full) begin
      drop_err <= 1'b1;
    end else if (clr_err) begin
      drop_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_out_fifo.sv
module tb_mux_out_fifo;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       clr_err;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       drop_err;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  logic [7:0] q[$];
  bit         m_err = 1'b0;

  mux_out_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_count"},     32'(count),     32'(q.size()));
    chk({tag, "_full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, "_empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, "_in_ready"},  32'(in_ready),  32'(q.size() != DEPTH));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    chk({tag, "_drop_err"},  32'(drop_err),  32'(m_err));
    if (q.size() != 0) chk({tag, "_out_data"}, 32'(out_data), 32'(q[0]));
  endtask

  // One clock cycle: drive after the falling edge, check the head before the
  // rising edge, advance the reference queue, then check status after it.
  task automatic cycle(input string tag, input logic v, input logic [7:0] d,
                       input logic r, input logic c);
    bit do_push;
    bit do_pop;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r; clr_err = c;
    #1;
    chk({tag, "_pre_out_valid"}, 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk({tag, "_pre_head"}, 32'(out_data), 32'(q[0]));
    @(posedge clk);
    do_push = v && (q.size() < DEPTH);
    do_pop  = r && (q.size() > 0);
    if (v && q.size() == DEPTH) m_err = 1'b1;
    else if (c)                 m_err = 1'b0;
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back(d);
    #1;
    chk_status(tag);
  endtask

  // Asynchronous reset away from any clock edge, checked before the next edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_err = 1'b0;
    chk_status(tag);
    in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] seq [4];
    seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'hFF; seq[3] = 8'h01;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_err = 1'b0;
    #12;
    chk_status("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    cycle("idle0", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("idle1", 1'b0, 8'h00, 1'b1, 1'b0);

    // Fill with the fixed pattern, nothing consumed
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, seq[i], 1'b0, 1'b0);
    chk("fill_full", 32'(full), 32'(1));
    chk("fill_head", 32'(out_data), 32'h A5);

    // Offer while full, then clear the sticky flag
    cycle("drop", 1'b1, 8'h77, 1'b0, 1'b0);
    cycle("drop_hold", 1'b0, 8'h00, 1'b0, 1'b0);
    cycle("clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // Full and popping while offering: no write, drop still flagged
    cycle("full_pop", 1'b1, 8'h99, 1'b1, 1'b0);
    cycle("clr_vs_drop", 1'b1, 8'h42, 1'b0, 1'b1);
    cycle("clr2", 1'b0, 8'h00, 1'b0, 1'b1);

    // Drain to two entries, then stream across pointer wraps
    cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle("stream", 1'b1, 8'(8'h20 + i), 1'b1, 1'b0);

    // Pop to empty, then a single push appears one edge later
    while (q.size() != 0) cycle("empty_out", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("push_5a", 1'b1, 8'h5A, 1'b0, 1'b0);
    chk("push_5a_data", 32'(out_data), 32'h5A);
    cycle("pop_5a", 1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-stream at count 3
    for (int i = 0; i < 3; i++) cycle("pre_rst", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    async_reset("midrst");
    cycle("post_rst_push", 1'b1, 8'h11, 1'b0, 1'b0);
    cycle("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic against the reference queue
    for (int i = 0; i < 300; i++) begin
      cycle("rand", 1'($urandom_range(0, 99) < 60), 8'($urandom),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 8));
      if (i == 150) async_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
